// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: ready/valid pipeline stage.
//   SEL=1: registered two-entry skid stage. in_ready is decoded from state only,
//          so there is no combinational path from out_ready to in_ready.
//   SEL=0: combinational pass-through with no storage.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_data    write-side payload        in_valid   write-side valid
//   in_ready   write side may push
//   out_data   read-side payload         out_valid  read-side valid
//   out_ready  downstream accepts
//   count      stored entries (0..2), constant 0 when SEL=0
module pipe_skid_reg #(
  parameter int unsigned WIDTH = 18,
  parameter bit          SEL   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       count
);

  if (SEL) begin : g_skid
    // The encoding equals the stored-entry count, so count is the state itself.
    typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             push;
    logic             pop;

    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_q;
    assign count     = state_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= StEmpty;
        main_q  <= '0;
        skid_q  <= '0;
      end else begin
        unique case (state_q)
          StEmpty: begin
            if (push) begin
              state_q <= StOne;
              main_q  <= in_data;
            end
          end
          StOne: begin
            if (push && pop) begin
              main_q <= in_data;
            end else if (push) begin
              // Downstream stalled: park the new word behind the head.
              state_q <= StFull;
              skid_q  <= in_data;
            end else if (pop) begin
              state_q <= StEmpty;
            end
          end
          StFull: begin
            if (pop) begin
              state_q <= StOne;
              main_q  <= skid_q;
            end
          end
          default: state_q <= StEmpty;
        endcase
      end
    end
  end else begin : g_pass
    assign out_data  = in_data;
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign count     = 2'd0;

    // Clock and reset have no role in the pass-through.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: registered instance checked against a FIFO
// scoreboard plus per-scenario inline checks, and a pass-through instance.
module tb_pipe_skid_reg;

  localparam int unsigned W = 18;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   count;

  logic [W-1:0] p_in_data;
  logic         p_in_valid;
  logic         p_in_ready;
  logic [W-1:0] p_out_data;
  logic         p_out_valid;
  logic         p_out_ready;
  logic [1:0]   p_count;

  int           n_cmp;
  int           n_err;
  int           pops;
  bit           sb_en;
  bit           stall_q;
  logic [W-1:0] stall_data;
  logic [W-1:0] sb_q[$];

  pipe_skid_reg #(.WIDTH(W), .SEL(1'b1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  pipe_skid_reg #(.WIDTH(W), .SEL(1'b0)) u_pass (
    .clk       (clk),
    .rst       (rst),
    .in_data   (p_in_data),
    .in_valid  (p_in_valid),
    .in_ready  (p_in_ready),
    .out_data  (p_out_data),
    .out_valid (p_out_valid),
    .out_ready (p_out_ready),
    .count     (p_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: samples 1 time unit before each rising edge.
  always @(negedge clk) begin
    logic [W-1:0] exp_w;
    #4;
    if (rst && sb_en) begin
      if (stall_q) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== stall_data) begin
          n_err++;
          $display("FAIL stall_stable: got valid=%b data=%h, need valid=1 data=%h",
                   out_valid, out_data, stall_data);
        end
      end
      if (in_valid && in_ready) sb_q.push_back(in_data);
      if (out_valid && out_ready) begin
        n_cmp++;
        pops++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_pop: got data=%h with nothing outstanding", out_data);
        end else begin
          exp_w = sb_q.pop_front();
          if (out_data !== exp_w) begin
            n_err++;
            $display("FAIL sb_order: got %h, need %h", out_data, exp_w);
          end
        end
      end
      stall_q    = out_valid && !out_ready;
      stall_data = out_data;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic test_reset();
    rst = 1'b0; sb_en = 1'b0; sb_q.delete();
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, count, out_data, in_ready} !== {1'b0, 2'd0, {W{1'b0}}, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: got v=%b c=%0d d=%h ir=%b, need v=0 c=0 d=0 ir=1",
               out_valid, count, out_data, in_ready);
    end
    rst = 1'b1; sb_en = 1'b1;
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 18'h12345; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_data = 18'h3ffff;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 18'h12345) begin
      n_err++;
      $display("FAIL single_latency: got v=%b d=%h, need v=1 d=12345", out_valid, out_data);
    end
    @(negedge clk);
    n_cmp++;
    if (count !== 2'd0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_drain: got c=%0d v=%b, need c=0 v=0", count, out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 18'd1;
    @(negedge clk);
    in_data = 18'd2;
    @(negedge clk);
    n_cmp++;
    if (count !== 2'd2 || in_ready !== 1'b0 || out_data !== 18'd1) begin
      n_err++;
      $display("FAIL bp_full: got c=%0d ir=%b d=%h, need c=2 ir=0 d=1", count, in_ready, out_data);
    end
    in_data = 18'd3;
    @(negedge clk);
    n_cmp++;
    if (count !== 2'd2 || out_data !== 18'd1) begin
      n_err++;
      $display("FAIL bp_reject: got c=%0d d=%h, need c=2 d=1", count, out_data);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 18'd2 || count !== 2'd1) begin
      n_err++;
      $display("FAIL bp_second: got v=%b d=%h c=%0d, need v=1 d=2 c=1", out_valid, out_data, count);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_empty: got v=%b, need v=0", out_valid);
    end
    in_valid = 1'b1; in_data = 18'd3;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 18'd3) begin
      n_err++;
      $display("FAIL bp_repush: got v=%b d=%h, need v=1 d=3", out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    int start_pops;
    int bad_cnt;
    start_pops = pops;
    bad_cnt    = 0;
    out_ready  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_data = W'(i + 100);
      @(negedge clk);
      if (count !== 2'd1) bad_cnt++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (bad_cnt != 0) begin
      n_err++;
      $display("FAIL stream_count: got %0d cycles with count!=1, need 0", bad_cnt);
    end
    n_cmp++;
    if (pops - start_pops != 99) begin
      n_err++;
      $display("FAIL stream_rate: got %0d words out, need 99", pops - start_pops);
    end
    @(negedge clk);
    n_cmp++;
    if (count !== 2'd0) begin
      n_err++;
      $display("FAIL stream_drain: got c=%0d, need 0", count);
    end
  endtask

  task automatic test_random();
    logic ir_before;
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      ir_before = in_ready;
      out_ready = ~out_ready;
      #1;
      n_cmp++;
      if (in_ready !== ir_before) begin
        n_err++;
        $display("FAIL ready_comb: got in_ready=%b after out_ready flip, need %b",
                 in_ready, ir_before);
      end
      out_ready = ~out_ready;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && (sb_q.size() != 0 || out_valid); i++) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL random_drain: got %0d outstanding v=%b, need 0 v=0", sb_q.size(), out_valid);
    end
  endtask

  task automatic test_reset_mid();
    sb_en = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 18'ha5;
    @(negedge clk);
    in_data = 18'h3c;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (count !== 2'd2 || out_data !== 18'ha5) begin
      n_err++;
      $display("FAIL rst_load: got c=%0d d=%h, need c=2 d=a5", count, out_data);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, count, out_data, in_ready} !== {1'b0, 2'd0, {W{1'b0}}, 1'b1}) begin
      n_err++;
      $display("FAIL rst_async: got v=%b c=%0d d=%h ir=%b, need v=0 c=0 d=0 ir=1",
               out_valid, count, out_data, in_ready);
    end
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || count !== 2'd0) begin
      n_err++;
      $display("FAIL rst_stale: got v=%b c=%0d, need v=0 c=0", out_valid, count);
    end
    sb_q.delete(); sb_en = 1'b1;
    // First push after release must land.
    in_valid = 1'b1; in_data = 18'h2_0001;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 18'h2_0001) begin
      n_err++;
      $display("FAIL rst_first_push: got v=%b d=%h, need v=1 d=20001", out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_sel0();
    for (int i = 0; i < 16; i++) begin
      p_in_valid  = i[0];
      p_out_ready = i[1];
      p_in_data   = W'($urandom);
      #1;
      n_cmp++;
      if (p_out_data !== p_in_data || p_out_valid !== p_in_valid ||
          p_in_ready !== p_out_ready || p_count !== 2'd0) begin
        n_err++;
        $display("FAIL sel0_pass: got d=%h v=%b ir=%b c=%0d, need d=%h v=%b ir=%b c=0",
                 p_out_data, p_out_valid, p_in_ready, p_count,
                 p_in_data, p_in_valid, p_out_ready);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; pops = 0; sb_en = 1'b0; stall_q = 1'b0; stall_data = '0;
    p_in_data = '0; p_in_valid = 1'b0; p_out_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_random();
    test_reset_mid();
    test_sel0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter: WIDTH, default 18, data path width in bits.
REQ-002 Parameter: SEL, default 1; 1 = registered two-entry skid stage, 0 = combinational pass-through.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk by upstream.
REQ-005 Port: in_data  input  WIDTH  write-side payload.
REQ-006 Port: in_valid  input  1  write-side payload valid.
REQ-007 Port: in_ready  output  1  block can accept in_data this cycle.
REQ-008 Port: out_data  output  WIDTH  read-side payload.
REQ-009 Port: out_valid  output  1  out_data valid.
REQ-010 Port: out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 Port: count  output  2  stored entries (0..2); constant 0 when SEL=0.

Function
REQ-012 Push = in_valid & in_ready at rising clk; pop = out_valid & out_ready at rising clk.
REQ-013 SEL=1 SHALL implement states EMPTY (count 0), ONE (count 1), FULL (count 2), held in a main register and a skid register.
REQ-014 out_data SHALL always drive the main register; out_valid = (state != EMPTY).
REQ-015 in_ready SHALL decode from state only, = (state != FULL); no combinational path from out_ready or in_valid to in_ready.
REQ-016 EMPTY: push -> ONE, main <= in_data; no push -> stay EMPTY.
REQ-017 ONE: push & pop -> ONE, main <= in_data; push & !pop -> FULL, skid <= in_data; !push & pop -> EMPTY; neither -> hold.
REQ-018 FULL: pop -> ONE, main <= skid; no pop -> hold both registers; push impossible (in_ready=0).
REQ-019 Latency SEL=1: word pushed into EMPTY appears on out_data with out_valid=1 in the cycle after the push edge (1 cycle).
REQ-020 Ordering SHALL be strict FIFO; no word dropped, duplicated or reordered under any valid/ready pattern.
REQ-021 Full throughput: continuous in_valid=1 and out_ready=1 SHALL sustain one transfer per cycle in state ONE.
REQ-022 out_data and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 in_data is ignored when in_valid=0; out_ready is ignored when out_valid=0.
REQ-024 SEL=0: out_data=in_data, out_valid=in_valid, in_ready=out_ready, combinationally; no storage; rst and clk have no effect.
REQ-025 Registers not loaded in a cycle SHALL hold their value.

Reset
REQ-026 rst=0 SHALL asynchronously force state EMPTY, main and skid to 0, giving out_valid=0, out_data=0, count=0, in_ready=1.
REQ-027 Reset asserted in ONE or FULL SHALL discard stored words; no stale word appears after release.
REQ-028 First push accepted on first rising clk with rst=1.

Verification
REQ-029 Reset: load FULL (A5, 3C), assert rst mid-cycle -> out_valid=0, count=0, out_data=0 immediately, before next edge.
REQ-030 Single word: push 0x12345 into EMPTY, out_ready=1 -> next cycle out_valid=1, out_data=0x12345; following cycle count=0.
REQ-031 Back-pressure: out_ready=0, push 1,2 -> count=2, in_ready=0, out_data=1; push attempt of 3 not accepted; then out_ready=1 -> outputs 1,2 on consecutive cycles, then 3 after re-push.
REQ-032 Streaming: in_valid=out_ready=1 for 100 cycles, incrementing data -> 99 words out in order, one per cycle, count stays 1.
REQ-033 Random valid/ready (10k cycles, scoreboard) -> no loss, duplication or reorder; out_data stable while stalled; in_ready never depends combinationally on out_ready.
REQ-034 SEL=0: toggle in_valid, out_ready, in_data -> outputs track inputs with zero delay; count=0.
